// File: rtl/drum_pkg.sv
// Shared constants for the DRUM product accumulator: default widths and the
// two's-complement saturation limits of an AW-bit accumulator.
package drum_pkg;

    localparam int unsigned DRUM_PW = 8;
    localparam int unsigned DRUM_AW = 16;
    localparam int unsigned DRUM_CW = 8;

    function automatic longint sat_hi(input int unsigned aw);
        return (longint'(1) << (aw - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int unsigned aw);
        return -(longint'(1) << (aw - 1));
    endfunction

endpackage

// File: rtl/drum_oc2tc.sv
// Ones'-complement product to two's-complement value, sign-extended to AW+1 bits.
// Negative -0 (all ones) lands on 0 because the +1 carries out of the field.
module drum_oc2tc
    import drum_pkg::*;
#(
    parameter int unsigned PW = DRUM_PW,
    parameter int unsigned AW = DRUM_AW
) (
    input  logic [PW-1:0] prod,
    output logic [AW:0]   val
);

    always_comb begin
        val = {{(AW + 1 - PW){prod[PW-1]}}, prod} + (AW + 1)'(prod[PW-1]);
    end

endmodule

// File: rtl/drum_acc.sv
// Two-stage saturating frame accumulator for DRUM ones'-complement products:
// stage 1 converts and registers the beat, stage 2 sums it into the frame.
module drum_acc
    import drum_pkg::*;
#(
    parameter int unsigned PW = DRUM_PW,
    parameter int unsigned AW = DRUM_AW,
    parameter int unsigned CW = DRUM_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_acc,
    output logic [CW-1:0] out_cnt,
    output logic          out_sat
);

    localparam logic signed [AW:0]   ACC_HI  = (AW + 1)'(sat_hi(AW));
    localparam logic signed [AW:0]   ACC_LO  = (AW + 1)'(sat_lo(AW));
    localparam logic        [CW-1:0] CNT_MAX = '1;

    logic               s1_valid;
    logic               s1_last;
    logic signed [AW:0] s1_val;
    logic        [AW:0] conv_val;

    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          sat;

    logic               accept;
    logic               advance;
    logic               clamp_hit;
    logic signed [AW:0] sum;
    logic [AW-1:0]      acc_nxt;
    logic [CW-1:0]      cnt_nxt;

    drum_oc2tc #(.PW(PW), .AW(AW)) u_oc2tc (
        .prod (in_prod),
        .val  (conv_val)
    );

    // Only a last beat can collide with an unconsumed result; other beats always drain.
    always_comb begin
        advance   = s1_valid & ~(s1_last & out_valid & ~out_ready);
        in_ready  = ~s1_valid | advance;
        accept    = in_valid & in_ready;
        sum       = {acc[AW-1], acc} + s1_val;
        clamp_hit = 1'b0;
        acc_nxt   = sum[AW-1:0];
        if (sum > ACC_HI) begin
            acc_nxt   = ACC_HI[AW-1:0];
            clamp_hit = 1'b1;
        end else if (sum < ACC_LO) begin
            acc_nxt   = ACC_LO[AW-1:0];
            clamp_hit = 1'b1;
        end
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_val    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_last  <= in_last;
                s1_val   <= conv_val;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A last beat advancing in the consume cycle reloads the port, keeping out_valid high.
            if (advance) begin
                if (s1_last) begin
                    out_valid <= 1'b1;
                    out_acc   <= acc_nxt;
                    out_cnt   <= cnt_nxt;
                    out_sat   <= sat | clamp_hit;
                    acc       <= '0;
                    cnt       <= '0;
                    sat       <= 1'b0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    sat <= sat | clamp_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_drum_acc.sv
// Directed bench for drum_acc: an AW=16 and an AW=8 instance checked against a
// frame-level arithmetic model, plus literal expectations for each scenario.
module tb_drum_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv16 = 1'b0, ir16, il16 = 1'b0, ov16, or16 = 1'b1, os16;
    logic [7:0]  ip16 = '0;
    logic [15:0] oa16;
    logic [7:0]  oc16;

    logic       iv8 = 1'b0, ir8, il8 = 1'b0, ov8, or8 = 1'b1, os8;
    logic [7:0] ip8 = '0;
    logic [7:0] oa8;
    logic [7:0] oc8;

    always #5 clk = ~clk;

    drum_acc #(.PW(8), .AW(16), .CW(8)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16), .in_prod(ip16), .in_last(il16),
        .out_valid(ov16), .out_ready(or16),
        .out_acc(oa16), .out_cnt(oc16), .out_sat(os16)
    );

    drum_acc #(.PW(8), .AW(8), .CW(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_prod(ip8), .in_last(il8),
        .out_valid(ov8), .out_ready(or8),
        .out_acc(oa8), .out_cnt(oc8), .out_sat(os8)
    );

    typedef struct {
        int acc;
        int cnt;
        int sat;
    } res_t;

    int checks = 0;
    int errors = 0;

    res_t q16[$];
    res_t q8[$];
    int   macc[2];
    int   mcnt[2];
    int   msat[2];

    int hold[2];
    int hacc[2];
    int hcnt[2];
    int hsat[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            macc[i] = 0;
            mcnt[i] = 0;
            msat[i] = 0;
            hold[i] = 0;
        end
        q16.delete();
        q8.delete();
    endtask

    // Frame-level model: signed value of each product, clamped running sum.
    task automatic model_accept(input int w, input logic [7:0] p, input bit last);
        logic [7:0] inv;
        int v, s, hi, lo, aw;
        res_t r;
        aw  = (w != 0) ? 8 : 16;
        hi  = (1 << (aw - 1)) - 1;
        lo  = -(1 << (aw - 1));
        inv = ~p;
        v   = p[7] ? -int'(inv) : int'(p);
        s   = macc[w] + v;
        if (s > hi) begin
            s = hi;
            msat[w] = 1;
        end else if (s < lo) begin
            s = lo;
            msat[w] = 1;
        end
        macc[w] = s;
        mcnt[w] = (mcnt[w] == 255) ? 255 : mcnt[w] + 1;
        if (last) begin
            r.acc = macc[w];
            r.cnt = mcnt[w];
            r.sat = msat[w];
            if (w != 0) q8.push_back(r);
            else        q16.push_back(r);
            macc[w] = 0;
            mcnt[w] = 0;
            msat[w] = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int w, input logic [7:0] p, input bit last);
        int g;
        g = 0;
        if (w != 0) begin
            iv8 = 1'b1; ip8 = p; il8 = last;
        end else begin
            iv16 = 1'b1; ip16 = p; il16 = last;
        end
        while ((((w != 0) ? ir8 : ir16) == 1'b0) && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("send_ready_bound", int'(g < 50), 1);
        @(posedge clk);
        model_accept(w, p, last);
        #1;
        if (w != 0) iv8 = 1'b0;
        else        iv16 = 1'b0;
    endtask

    task automatic cmp_port(input int w);
        logic v, r;
        int a, c, s;
        res_t e;
        v = (w != 0) ? ov8 : ov16;
        r = (w != 0) ? or8 : or16;
        a = (w != 0) ? int'($signed(oa8)) : int'($signed(oa16));
        c = (w != 0) ? int'(oc8) : int'(oc16);
        s = (w != 0) ? int'(os8) : int'(os16);
        if (v) begin
            if (hold[w] != 0) begin
                chk("stable_acc", a, hacc[w]);
                chk("stable_cnt", c, hcnt[w]);
                chk("stable_sat", s, hsat[w]);
            end
            if (r) begin
                hold[w] = 0;
                if (w != 0) begin
                    chk("result_expected8", int'(q8.size() > 0), 1);
                    if (q8.size() > 0) e = q8.pop_front();
                    else continue_dummy(e);
                end else begin
                    chk("result_expected16", int'(q16.size() > 0), 1);
                    if (q16.size() > 0) e = q16.pop_front();
                    else continue_dummy(e);
                end
                chk("model_acc", a, e.acc);
                chk("model_cnt", c, e.cnt);
                chk("model_sat", s, e.sat);
            end else begin
                hold[w] = 1;
                hacc[w] = a;
                hcnt[w] = c;
                hsat[w] = s;
            end
        end else begin
            hold[w] = 0;
        end
    endtask

    task automatic continue_dummy(output res_t e);
        e.acc = -999999;
        e.cnt = -1;
        e.sat = -1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                hold[0] = 0;
                hold[1] = 0;
            end else begin
                cmp_port(0);
                cmp_port(1);
            end
        end
    endtask

    initial begin
        model_clear();
        fork
            compare_loop();
            begin
                #100000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid16", int'(ov16), 0);
        chk("rst_out_acc16", int'(oa16), 0);
        chk("rst_out_cnt16", int'(oc16), 0);
        chk("rst_out_sat16", int'(os16), 0);
        chk("rst_in_ready16", int'(ir16), 1);
        chk("rst_out_valid8", int'(ov8), 0);
        chk("rst_in_ready8", int'(ir8), 1);

        // 6 + 15 - 15 = 6; result visible one edge after the last beat's accepting edge.
        send(0, 8'h06, 1'b0);
        send(0, 8'h0F, 1'b0);
        send(0, 8'hF0, 1'b1);
        chk("lat_not_yet", int'(ov16), 0);
        @(posedge clk); #1;
        chk("lat_valid", int'(ov16), 1);
        chk("f1_acc", int'($signed(oa16)), 6);
        chk("f1_cnt", int'(oc16), 3);
        chk("f1_sat", int'(os16), 0);

        send(0, 8'hFF, 1'b1);
        @(posedge clk); #1;
        chk("neg0_acc", int'($signed(oa16)), 0);
        chk("neg0_cnt", int'(oc16), 1);

        // 49 + 49 + 49 clamps at 127 in 8 bits; the next frame starts clean.
        send(1, 8'h31, 1'b0);
        send(1, 8'h31, 1'b0);
        send(1, 8'h31, 1'b1);
        @(posedge clk); #1;
        chk("aw8_sat_acc", int'($signed(oa8)), 127);
        chk("aw8_sat_flag", int'(os8), 1);
        chk("aw8_sat_cnt", int'(oc8), 3);
        send(1, 8'hCE, 1'b1);
        @(posedge clk); #1;
        chk("aw8_neg_acc", int'(oa8), 8'hCF);
        chk("aw8_neg_sat", int'(os8), 0);
        chk("aw8_neg_cnt", int'(oc8), 1);

        or16 = 1'b0;
        send(0, 8'h09, 1'b1);
        @(posedge clk); #1;
        chk("bp_pending", int'(ov16), 1);
        send(0, 8'h01, 1'b0);
        send(0, 8'h02, 1'b1);
        chk("bp_in_ready_low", int'(ir16), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_held", int'(ir16), 0);
        chk("bp_acc_held", int'($signed(oa16)), 9);
        or16 = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_valid", int'(ov16), 1);
        chk("bp_next_acc", int'($signed(oa16)), 3);
        chk("bp_next_cnt", int'(oc16), 2);
        @(posedge clk); #1;

        send(0, 8'h01, 1'b1);
        send(0, 8'h02, 1'b1);
        chk("b2b_valid1", int'(ov16), 1);
        chk("b2b_acc1", int'($signed(oa16)), 1);
        send(0, 8'h03, 1'b1);
        chk("b2b_valid2", int'(ov16), 1);
        chk("b2b_acc2", int'($signed(oa16)), 2);
        @(posedge clk); #1;
        chk("b2b_valid3", int'(ov16), 1);
        chk("b2b_acc3", int'($signed(oa16)), 3);
        @(posedge clk); #1;

        send(0, 8'h05, 1'b0);
        send(0, 8'h05, 1'b0);
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", int'(ov16), 0);
        send(0, 8'h02, 1'b1);
        @(posedge clk); #1;
        chk("midrst_valid2", int'(ov16), 1);
        chk("midrst_acc", int'($signed(oa16)), 2);
        chk("midrst_cnt", int'(oc16), 1);

        repeat (4) @(posedge clk);
        #1;
        chk("drain16", q16.size(), 0);
        chk("drain8", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
